// File: rtl/fb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fb_pkg : shared types and default geometry for the video frame buffer
// Rev 1.0
// ============================================================================
package fb_pkg;

   localparam int FB_WIDTH      = 200;
   localparam int FB_HEIGHT     = 150;
   localparam int FB_PIXEL_BITS = 1;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fb_ram : two-bank simple dual-port pixel RAM with registered read
// Rev 1.0
// ============================================================================
module fb_ram #(
   parameter int WORDS  = 12,
   parameter int ADDRW  = 4,
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              wsel_i,
   input  logic [ADDRW-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic              rsel_i,
   input  logic [ADDRW-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int              IDXW       = ADDRW + 1;
   localparam int              DEPTH      = 2 * WORDS;
   localparam logic [IDXW-1:0] BANK1_BASE = IDXW'(WORDS);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [IDXW-1:0]   widx_d;
   logic [IDXW-1:0]   ridx_d;

   // Bank 1 starts at WORDS rather than 2**ADDRW so the array stays exactly 2*WORDS deep.
   assign widx_d = wsel_i ? (BANK1_BASE + {1'b0, waddr_i}) : {1'b0, waddr_i};
   assign ridx_d = rsel_i ? (BANK1_BASE + {1'b0, raddr_i}) : {1'b0, raddr_i};

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[widx_d] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[ridx_d];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/video_frame_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// video_frame_buffer : double-buffered pixel store, stream writes / x,y reads
// Rev 1.0
// ============================================================================
module video_frame_buffer
   import fb_pkg::*;
#(
   parameter int                    WIDTH      = FB_WIDTH,
   parameter int                    HEIGHT     = FB_HEIGHT,
   parameter int                    PIXEL_BITS = FB_PIXEL_BITS,
   parameter logic [PIXEL_BITS-1:0] BG_COLOR   = '0,
   parameter int                    CNT_W      = 8,
   parameter int                    X_ADDRW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
   parameter int                    Y_ADDRW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
   parameter int                    ADDRW      = (WIDTH*HEIGHT > 1) ? $clog2(WIDTH*HEIGHT) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [PIXEL_BITS-1:0] wr_data,
   input  logic                  wr_sof,
   input  logic                  frame_sync,
   input  logic                  rd_en,
   input  logic [X_ADDRW-1:0]    x_pos,
   input  logic [Y_ADDRW-1:0]    y_pos,
   output logic [PIXEL_BITS-1:0] pixel_color,
   output logic                  pixel_valid,
   output logic                  frame_ready,
   output logic                  front_sel,
   output logic [CNT_W-1:0]      underrun_cnt
);

   localparam int                 WORDS     = WIDTH * HEIGHT;
   localparam logic [ADDRW-1:0]   LAST_ADDR = ADDRW'(WORDS - 1);
   localparam logic [ADDRW-1:0]   LINE_LEN  = ADDRW'(WIDTH);
   localparam logic [X_ADDRW:0]   X_LIM     = (X_ADDRW + 1)'(WIDTH);
   localparam logic [Y_ADDRW:0]   Y_LIM     = (Y_ADDRW + 1)'(HEIGHT);

   fb_state_t         state_q;
   logic [ADDRW-1:0]  wr_addr_q;
   logic              wr_ready_q;
   logic              front_q;
   logic              frame_ready_q;
   logic [CNT_W-1:0]  underrun_q;

   logic              beat_d;
   logic [ADDRW-1:0]  beat_addr_d;
   logic              last_beat_d;

   logic [ADDRW-1:0]  rd_addr_d;
   logic              in_range_d;
   logic [ADDRW-1:0]  rd_addr_q;
   logic              rd_buf_q;
   logic              rd_en_d1_q;
   logic              in_range_d1_q;
   logic              rd_en_d2_q;
   logic              in_range_d2_q;
   logic [PIXEL_BITS-1:0] ram_rdata;

   // A start-of-frame beat always lands at pixel 0, regardless of the running counter.
   assign beat_d      = wr_valid & wr_ready_q;
   assign beat_addr_d = wr_sof ? '0 : wr_addr_q;
   assign last_beat_d = beat_d && (beat_addr_d == LAST_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FILL;
         wr_addr_q     <= '0;
         wr_ready_q    <= 1'b1;
         front_q       <= 1'b0;
         frame_ready_q <= 1'b0;
         underrun_q    <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (beat_d) begin
                  wr_addr_q <= last_beat_d ? '0 : beat_addr_d + 1'b1;
               end
               if (last_beat_d && frame_sync) begin
                  front_q <= ~front_q;
               end else if (last_beat_d) begin
                  state_q       <= FULL;
                  wr_ready_q    <= 1'b0;
                  frame_ready_q <= 1'b1;
               end else if (frame_sync && (underrun_q != '1)) begin
                  underrun_q <= underrun_q + 1'b1;
               end
            end
            FULL: begin
               if (frame_sync) begin
                  state_q       <= FILL;
                  wr_ready_q    <= 1'b1;
                  front_q       <= ~front_q;
                  frame_ready_q <= 1'b0;
                  wr_addr_q     <= '0;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign rd_addr_d  = ADDRW'(y_pos) * LINE_LEN + ADDRW'(x_pos);
   assign in_range_d = ({1'b0, x_pos} < X_LIM) && ({1'b0, y_pos} < Y_LIM);

   // Address, bank and range flag only advance on a request so the output holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr_q     <= '0;
         rd_buf_q      <= 1'b0;
         rd_en_d1_q    <= 1'b0;
         in_range_d1_q <= 1'b0;
         rd_en_d2_q    <= 1'b0;
         in_range_d2_q <= 1'b0;
      end else begin
         rd_en_d1_q <= rd_en;
         rd_en_d2_q <= rd_en_d1_q;
         if (rd_en) begin
            rd_addr_q     <= rd_addr_d;
            rd_buf_q      <= front_q;
            in_range_d1_q <= in_range_d;
         end
         if (rd_en_d1_q) begin
            in_range_d2_q <= in_range_d1_q;
         end
      end
   end

   fb_ram #(
      .WORDS  (WORDS),
      .ADDRW  (ADDRW),
      .DATA_W (PIXEL_BITS)
   ) u_ram (
      .clk     (clk),
      .we_i    (beat_d),
      .wsel_i  (~front_q),
      .waddr_i (beat_addr_d),
      .wdata_i (wr_data),
      .re_i    (rd_en_d1_q),
      .rsel_i  (rd_buf_q),
      .raddr_i (rd_addr_q),
      .rdata_o (ram_rdata)
   );

   assign pixel_color  = in_range_d2_q ? ram_rdata : BG_COLOR;
   assign pixel_valid  = rd_en_d2_q;
   assign wr_ready     = wr_ready_q;
   assign frame_ready  = frame_ready_q;
   assign front_sel    = front_q;
   assign underrun_cnt = underrun_q;

endmodule
`default_nettype wire
